// File: rtl/uni_shift_pkg.sv
// Shared types for the universal shift register: mode encoding and counter sizing.
package uni_shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } shift_mode_t;

    // Counter must hold 0..WIDTH-1; sized for WIDTH+1 so it is at least one bit.
    function automatic int calc_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// Counts shift edges and raises a registered one-cycle frame_done after every WIDTH-th shift.
// Clear and load restart the count; hold freezes it.
module shift_frame_counter
    import uni_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = calc_cw(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          shift_en,
    input  logic          load,
    output logic [CW-1:0] cnt,
    output logic          frame_done
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_done_q, frame_done_d;

    always_comb begin
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        if (clr || load) begin
            cnt_d = '0;
        end else if (shift_en) begin
            if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cnt        = cnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: rtl/uni_shift_register.sv
// Parametrised universal shift register (hold / shift right / shift left / load) with frame counter.
// Optional rotate input enabled by macro UNI_SHIFT_ROTATE_EN.
module uni_shift_register
    import uni_shift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = calc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef UNI_SHIFT_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    cnt,
    output logic             frame_done
);

    shift_mode_t      mode_e;
    logic             rot_en;
    logic             shr_in, shl_in;
    logic             shift_en, load_en;
    logic [WIDTH-1:0] pout_q, pout_d;

    assign mode_e = shift_mode_t'(mode);

`ifdef UNI_SHIFT_ROTATE_EN
    assign rot_en = rot;
`else
    assign rot_en = 1'b0;
`endif

    // On rotate the departing bit re-enters at the opposite end.
    assign shr_in = rot_en ? pout_q[0]       : sin_r;
    assign shl_in = rot_en ? pout_q[WIDTH-1] : sin_l;

    assign shift_en = (mode_e == MODE_SHR) || (mode_e == MODE_SHL);
    assign load_en  = (mode_e == MODE_LOAD);

    always_comb begin
        pout_d = pout_q;
        if (clr) begin
            pout_d = RESET_VAL;
        end else begin
            unique case (mode_e)
                MODE_HOLD: pout_d = pout_q;
                MODE_SHR:  pout_d = {shr_in, pout_q[WIDTH-1:1]};
                MODE_SHL:  pout_d = {pout_q[WIDTH-2:0], shl_in};
                MODE_LOAD: pout_d = pin;
                default:   pout_d = pout_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pout_q <= RESET_VAL;
        end else begin
            pout_q <= pout_d;
        end
    end

    shift_frame_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .shift_en  (shift_en),
        .load      (load_en),
        .cnt       (cnt),
        .frame_done(frame_done)
    );

    assign pout   = pout_q;
    assign sout_r = pout_q[0];
    assign sout_l = pout_q[WIDTH-1];

endmodule

// File: tb/tb_uni_shift_register.sv
// Randomised and directed bench for uni_shift_register (WIDTH=8) against an arithmetic reference model.
module tb_uni_shift_register;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         clr;
    logic [1:0]   mode;
    logic         sin_r;
    logic         sin_l;
    logic         rot;
    logic [W-1:0] pin;
    logic [W-1:0] pout;
    logic         sout_r;
    logic         sout_l;
    logic [3:0]   cnt;
    logic         frame_done;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_val;
    int m_shifts;
    int m_fd;

    uni_shift_register #(
        .WIDTH    (W),
        .RESET_VAL('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .mode      (mode),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
`ifdef UNI_SHIFT_ROTATE_EN
        .rot       (rot),
`endif
        .pin       (pin),
        .pout      (pout),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .cnt       (cnt),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val    = 0;
        m_shifts = 0;
        m_fd     = 0;
    endtask

    // Next state from the current inputs, expressed as word arithmetic.
    task automatic model_step();
        int entering;
        if (clr) begin
            model_reset();
        end else begin
            case (mode)
                2'b00: m_fd = 0;
                2'b11: begin
                    m_val    = int'(pin);
                    m_shifts = 0;
                    m_fd     = 0;
                end
                default: begin
                    if (mode == 2'b01) begin
                        entering = (rot === 1'b1) ? (m_val % 2) : int'(sin_r);
                        m_val    = (m_val / 2) + entering * (1 << (W - 1));
                    end else begin
                        entering = (rot === 1'b1) ? (m_val / (1 << (W - 1))) : int'(sin_l);
                        m_val    = ((m_val * 2) + entering) % (1 << W);
                    end
                    m_shifts = m_shifts + 1;
                    if (m_shifts == W) begin
                        m_shifts = 0;
                        m_fd     = 1;
                    end else begin
                        m_fd = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pout"},   32'(pout),       32'(m_val));
        check({tag, ".cnt"},    32'(cnt),        32'(m_shifts));
        check({tag, ".fd"},     32'(frame_done), 32'(m_fd));
        check({tag, ".sout_r"}, 32'(sout_r),     32'(m_val % 2));
        check({tag, ".sout_l"}, 32'(sout_l),     32'(m_val / (1 << (W - 1))));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input logic c, input logic [1:0] m, input logic sr, input logic sl, input logic [W-1:0] p);
        clr   = c;
        mode  = m;
        sin_r = sr;
        sin_l = sl;
        pin   = p;
    endtask

    initial begin
        logic [7:0] rseq;
        int pulses;
        int last_pulse;
        rst = 1'b1;
        rot = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0, '0);
        model_reset();
        #2;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-frame at cnt=5
        drive(1'b0, 2'b10, 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) tick("pre_rst");
        check("cnt_before_rst", 32'(cnt), 32'd5);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Right shift of a known serial pattern
        rseq = 8'b1010_0011;
        for (int i = 0; i < W; i++) begin
            drive(1'b0, 2'b01, rseq[i], 1'b0, '0);
            tick("shr_seq");
            if (i < W - 1) check("shr_no_fd", 32'(frame_done), 32'd0);
        end
        check("shr_A3", 32'(pout), 32'hA3);
        check("shr_fd", 32'(frame_done), 32'd1);
        check("shr_cnt0", 32'(cnt), 32'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, '0);
        tick("fd_drop");
        check("fd_one_cycle", 32'(frame_done), 32'd0);

        // Load then left shift
        drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h81);
        tick("load81");
        check("load_cnt0", 32'(cnt), 32'd0);
        check("load_soutl", 32'(sout_l), 32'd1);
        drive(1'b0, 2'b10, 1'b0, 1'b0, '0);
        tick("shl");
        check("shl_02", 32'(pout), 32'h02);
        check("shl_soutl", 32'(sout_l), 32'd0);

        // Hold mid-frame
        drive(1'b0, 2'b00, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) tick("hold");
        check("hold_pout", 32'(pout), 32'h02);
        check("hold_cnt", 32'(cnt), 32'd1);

        // Clear after loading FF, then clear beats load
        drive(1'b0, 2'b11, 1'b0, 1'b0, 8'hFF);
        tick("loadFF");
        drive(1'b1, 2'b00, 1'b0, 1'b0, '0);
        tick("clr");
        check("clr_pout", 32'(pout), 32'h00);
        drive(1'b0, 2'b01, 1'b1, 1'b0, '0);
        tick("shr1");
        drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h5A);
        tick("clr_over_load");
        check("clr_prio", 32'(pout), 32'h00);

        // Load at cnt=7 suppresses the frame pulse
        drive(1'b0, 2'b01, 1'b1, 1'b0, '0);
        for (int i = 0; i < W - 1; i++) tick("to7");
        check("cnt7", 32'(cnt), 32'd7);
        drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h3C);
        tick("load_at7");
        check("load7_no_fd", 32'(frame_done), 32'd0);

        // Continuous streaming
        drive(1'b0, 2'b01, 1'b0, 1'b0, '0);
        pulses     = 0;
        last_pulse = -1;
        for (int i = 0; i < 3 * W; i++) begin
            sin_r = 1'($urandom_range(0, 1));
            tick("stream");
            if (frame_done) begin
                if (last_pulse >= 0) check("stream_gap", 32'(i - last_pulse), 32'(W));
                else check("stream_first", 32'(i), 32'(W - 1));
                last_pulse = i;
                pulses++;
            end
        end
        check("stream_pulses", 32'(pulses), 32'd3);

`ifdef UNI_SHIFT_ROTATE_EN
        drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h81);
        tick("rot_load");
        rot = 1'b1;
        drive(1'b0, 2'b01, 1'b0, 1'b0, '0);
        tick("rotr1");
        check("rotr_C0", 32'(pout), 32'hC0);
        drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h81);
        tick("rot_reload");
        pulses = 0;
        drive(1'b0, 2'b01, 1'b0, 1'b0, '0);
        for (int i = 0; i < W; i++) begin
            tick("rot8");
            if (frame_done) pulses++;
        end
        check("rot8_81", 32'(pout), 32'h81);
        check("rot8_pulse", 32'(pulses), 32'd1);
        rot = 1'b0;
`endif

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
`ifdef UNI_SHIFT_ROTATE_EN
            rot = 1'($urandom_range(0, 1));
`endif
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
